// File: rtl/ram_read_arb.sv
// Two-port read arbiter for the frame RAM. The framebuffer fetch has priority. The LED strip gets a
// forced grant after STARVE_MAX denied cycles. A swap FSM flips the displayed buffer on frame_start.
module ram_read_arb #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 20,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              sys_clk,
    input  logic              rst_n,

    input  logic              fb_req,
    input  logic [ADDR_W-1:0] fb_addr,
    output logic              fb_gnt,
    output logic              fb_rvalid,
    output logic [DATA_W-1:0] fb_rdata,

    input  logic              strip_req,
    input  logic [ADDR_W-1:0] strip_addr,
    output logic              strip_gnt,
    output logic              strip_rvalid,
    output logic [DATA_W-1:0] strip_rdata,

    output logic              ram_re,
    output logic [ADDR_W:0]   ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,

    input  logic              swap_req,
    input  logic              frame_start,
    output logic              active_buf,
    output logic              swap_ack
);

    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {StIdle, StPending} swap_state_e;

    swap_state_e      state_q, state_d;
    logic             active_buf_q, active_buf_d;
    logic             swap_ack_q, swap_ack_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [1:0]       tag_q, tag_d;
    logic             force_strip;
    logic             do_swap;

    assign force_strip = strip_req && (starve_q == CNT_W'(STARVE_MAX));

    always_comb begin
        fb_gnt    = 1'b0;
        strip_gnt = 1'b0;
        if (rst_n) begin
            fb_gnt    = fb_req && !force_strip;
            strip_gnt = strip_req && (!fb_req || force_strip);
        end
    end

    assign ram_re = fb_gnt | strip_gnt;

    // The buffer select uses the registered active_buf, so a toggle only affects later grants.
    always_comb begin
        ram_raddr = '0;
        if (fb_gnt) begin
            ram_raddr = {active_buf_q, fb_addr};
        end else if (strip_gnt) begin
            ram_raddr = {active_buf_q, strip_addr};
        end
    end

    always_comb begin
        starve_d = '0;
        if (strip_req && !strip_gnt) begin
            starve_d = (starve_q == CNT_W'(STARVE_MAX)) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    assign tag_d = {fb_gnt, strip_gnt};

    always_comb begin
        state_d = state_q;
        do_swap = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (swap_req && frame_start) begin
                    do_swap = 1'b1;
                end else if (swap_req) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (frame_start) begin
                    do_swap = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        active_buf_d = active_buf_q ^ do_swap;
        swap_ack_d   = do_swap;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            active_buf_q <= 1'b0;
            swap_ack_q   <= 1'b0;
            starve_q     <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            active_buf_q <= active_buf_d;
            swap_ack_q   <= swap_ack_d;
            starve_q     <= starve_d;
            tag_q        <= tag_d;
        end
    end

    // RAM has a fixed one-cycle latency, so read data passes straight through.
    assign fb_rvalid    = tag_q[1];
    assign strip_rvalid = tag_q[0];
    assign fb_rdata     = ram_rdata;
    assign strip_rdata  = ram_rdata;
    assign active_buf   = active_buf_q;
    // swap_ack rises in the first cycle that the new active_buf is visible.
    assign swap_ack     = swap_ack_q;

endmodule

// File: tb/tb_ram_read_arb.sv
// Directed bench for ram_read_arb. Inputs change on the falling edge and outputs are checked 1 ns
// later. Read returns are tracked in a queue of predicted responses.
module tb_ram_read_arb;

    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned DATA_W     = 20;
    localparam int unsigned STARVE_MAX = 8;

    logic              sys_clk = 1'b0;
    logic              rst_n;
    logic              fb_req, strip_req, swap_req, frame_start;
    logic [ADDR_W-1:0] fb_addr, strip_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              fb_gnt, fb_rvalid, strip_gnt, strip_rvalid, ram_re, active_buf, swap_ack;
    logic [DATA_W-1:0] fb_rdata, strip_rdata;
    logic [ADDR_W:0]   ram_raddr;

    typedef struct packed {
        logic              fb;
        logic              st;
        logic [DATA_W-1:0] data;
    } rd_t;

    rd_t               exp_q[$];
    int                total = 0;
    int                bad = 0;
    int                m_starve = 0;
    logic              m_buf = 1'b0;
    logic [DATA_W-1:0] nxt = '0;

    always #5 sys_clk = ~sys_clk;

    ram_read_arb #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .fb_req      (fb_req),
        .fb_addr     (fb_addr),
        .fb_gnt      (fb_gnt),
        .fb_rvalid   (fb_rvalid),
        .fb_rdata    (fb_rdata),
        .strip_req   (strip_req),
        .strip_addr  (strip_addr),
        .strip_gnt   (strip_gnt),
        .strip_rvalid(strip_rvalid),
        .strip_rdata (strip_rdata),
        .ram_re      (ram_re),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata),
        .swap_req    (swap_req),
        .frame_start (frame_start),
        .active_buf  (active_buf),
        .swap_ack    (swap_ack)
    );

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge sys_clk);
            #1;
            total++;
            if ({fb_gnt, strip_gnt, ram_re} !== 3'b000) begin
                bad++;
                $display("FAIL reset_gnt: got %b want 000", {fb_gnt, strip_gnt, ram_re});
            end
            total++;
            if ({fb_rvalid, strip_rvalid, active_buf, swap_ack} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_state: got %b want 0000",
                         {fb_rvalid, strip_rvalid, active_buf, swap_ack});
            end
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        fb_req = 1'b0;
        strip_req = 1'b0;
        m_buf = 1'b0;
        m_starve = 0;
    endtask

    task automatic test_single_fb();
        logic [DATA_W-1:0] d;
        rd_t r;
        d = 20'hA5C3E;
        @(negedge sys_clk);
        fb_req = 1'b1;
        fb_addr = 14'h0123;
        #1;
        total++;
        if ({fb_gnt, strip_gnt, ram_re} !== 3'b101) begin
            bad++;
            $display("FAIL single_gnt: got %b want 101", {fb_gnt, strip_gnt, ram_re});
        end
        total++;
        if (ram_raddr !== 15'h00123) begin
            bad++;
            $display("FAIL single_addr: got %h want 00123", ram_raddr);
        end
        exp_q.push_back('{fb: 1'b1, st: 1'b0, data: d});
        @(negedge sys_clk);
        fb_req = 1'b0;
        ram_rdata = d;
        #1;
        r = exp_q.pop_front();
        total++;
        if ({fb_rvalid, strip_rvalid} !== {r.fb, r.st} || fb_rdata !== r.data) begin
            bad++;
            $display("FAIL single_ret: got v=%b d=%h want v=%b d=%h",
                     {fb_rvalid, strip_rvalid}, fb_rdata, {r.fb, r.st}, r.data);
        end
        total++;
        if (ram_re !== 1'b0) begin
            bad++;
            $display("FAIL single_idle_re: got %b want 0", ram_re);
        end
    endtask

    // Drives a request pattern for n cycles against the arbitration model and scoreboard.
    task automatic test_arb_stream(input logic fb, input logic st, input int n);
        logic              e_force, e_fb, e_st;
        logic [ADDR_W:0]   e_addr;
        rd_t               r;
        for (int c = 0; c < n; c++) begin
            @(negedge sys_clk);
            fb_req = fb;
            strip_req = st;
            fb_addr = ADDR_W'($urandom);
            strip_addr = ADDR_W'($urandom);
            ram_rdata = nxt;
            e_force = st && (m_starve == STARVE_MAX);
            e_fb = fb && !e_force;
            e_st = st && (!fb || e_force);
            e_addr = e_fb ? {m_buf, fb_addr} : (e_st ? {m_buf, strip_addr} : '0);
            #1;
            total++;
            if ({fb_gnt, strip_gnt, ram_re} !== {e_fb, e_st, e_fb | e_st}) begin
                bad++;
                $display("FAIL arb_gnt c=%0d: got %b want %b", c, {fb_gnt, strip_gnt, ram_re},
                         {e_fb, e_st, e_fb | e_st});
            end
            total++;
            if (ram_raddr !== e_addr) begin
                bad++;
                $display("FAIL arb_addr c=%0d: got %h want %h", c, ram_raddr, e_addr);
            end
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                total++;
                if ({fb_rvalid, strip_rvalid} !== {r.fb, r.st} ||
                    (r.fb && fb_rdata !== r.data) || (r.st && strip_rdata !== r.data)) begin
                    bad++;
                    $display("FAIL arb_ret c=%0d: got v=%b fd=%h sd=%h want v=%b d=%h", c,
                             {fb_rvalid, strip_rvalid}, fb_rdata, strip_rdata, {r.fb, r.st},
                             r.data);
                end
            end else begin
                total++;
                if ({fb_rvalid, strip_rvalid} !== 2'b00) begin
                    bad++;
                    $display("FAIL arb_noret c=%0d: got %b want 00", c,
                             {fb_rvalid, strip_rvalid});
                end
            end
            nxt = DATA_W'($urandom);
            if (e_fb || e_st) exp_q.push_back('{fb: e_fb, st: e_st, data: nxt});
            if (st && !e_st) begin
                if (m_starve < STARVE_MAX) m_starve++;
            end else begin
                m_starve = 0;
            end
        end
    endtask

    task automatic test_swap_delayed();
        logic b0, e_buf;
        b0 = m_buf;
        for (int c = 0; c <= 56; c++) begin
            @(negedge sys_clk);
            fb_req = (c < 55);
            fb_addr = ADDR_W'($urandom);
            swap_req = (c == 10) || (c == 20);
            frame_start = (c == 5) || (c == 50);
            e_buf = (c >= 51) ? ~b0 : b0;
            #1;
            total++;
            if (active_buf !== e_buf || swap_ack !== (c == 51)) begin
                bad++;
                $display("FAIL swap_state c=%0d: got buf=%b ack=%b want buf=%b ack=%b", c,
                         active_buf, swap_ack, e_buf, c == 51);
            end
            if (c < 55) begin
                total++;
                if (ram_raddr !== {e_buf, fb_addr}) begin
                    bad++;
                    $display("FAIL swap_addr c=%0d: got %h want %h", c, ram_raddr,
                             {e_buf, fb_addr});
                end
            end
            total++;
            if (fb_rvalid !== (c >= 1 && c <= 55)) begin
                bad++;
                $display("FAIL swap_rvalid c=%0d: got %b want %b", c, fb_rvalid,
                         (c >= 1 && c <= 55));
            end
        end
        swap_req = 1'b0;
        frame_start = 1'b0;
        m_buf = ~b0;
    endtask

    task automatic test_swap_same_cycle();
        logic b0, e_buf;
        b0 = m_buf;
        for (int c = 0; c <= 10; c++) begin
            @(negedge sys_clk);
            swap_req = (c == 0) || (c == 2) || (c == 4);
            frame_start = (c == 0) || (c == 6) || (c == 9);
            e_buf = b0 ^ (c >= 1) ^ (c >= 7);
            #1;
            total++;
            if (active_buf !== e_buf || swap_ack !== (c == 1 || c == 7)) begin
                bad++;
                $display("FAIL swap_same c=%0d: got buf=%b ack=%b want buf=%b ack=%b", c,
                         active_buf, swap_ack, e_buf, (c == 1 || c == 7));
            end
        end
        swap_req = 1'b0;
        frame_start = 1'b0;
        m_buf = b0;
    endtask

    task automatic test_reset_inflight();
        @(negedge sys_clk);
        fb_req = 1'b0;
        strip_req = 1'b1;
        strip_addr = 14'h2AAA;
        #1;
        total++;
        if (strip_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_gnt: got %b want 1", strip_gnt);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge sys_clk);
            rst_n = 1'b0;
            fb_req = 1'b1;
            strip_req = 1'b1;
            #1;
            total++;
            if ({fb_gnt, strip_gnt, ram_re} !== 3'b000 || ram_raddr !== '0) begin
                bad++;
                $display("FAIL rst_gnt c=%0d: got %b addr=%h want 000 addr=0", c,
                         {fb_gnt, strip_gnt, ram_re}, ram_raddr);
            end
            if (c >= 2) begin
                total++;
                if ({fb_rvalid, strip_rvalid, active_buf, swap_ack} !== 4'b0000) begin
                    bad++;
                    $display("FAIL rst_state c=%0d: got %b want 0000", c,
                             {fb_rvalid, strip_rvalid, active_buf, swap_ack});
                end
            end
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        fb_req = 1'b0;
        strip_req = 1'b0;
        exp_q.delete();
        m_buf = 1'b0;
        m_starve = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        fb_req = 1'b1;
        strip_req = 1'b1;
        swap_req = 1'b0;
        frame_start = 1'b0;
        fb_addr = '0;
        strip_addr = '0;
        ram_rdata = '0;
        test_reset();
        test_single_fb();
        test_arb_stream(1'b1, 1'b1, 27);
        test_arb_stream(1'b0, 1'b0, 1);
        test_arb_stream(1'b0, 1'b1, 20);
        test_arb_stream(1'b1, 1'b1, 9);
        test_arb_stream(1'b0, 1'b0, 2);
        test_swap_delayed();
        test_arb_stream(1'b1, 1'b0, 3);
        test_arb_stream(1'b0, 1'b1, 3);
        test_arb_stream(1'b0, 1'b0, 1);
        test_swap_same_cycle();
        test_reset_inflight();
        test_arb_stream(1'b1, 1'b1, 9);
        test_arb_stream(1'b0, 1'b0, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
